board_frame_renderer: RTL

Parametrised board renderer for the checkers VGA path. It sits between the packed board-state vector and the frame-buffer write port of the VGA frame driver. On each start request it snapshots the board and cursor, then sweeps every virtual pixel of the reduced-resolution frame buffer once, writing one colour word per pixel. It supports any square board size, cell width, cell size and placement, a highlighted cursor cell, and write back-pressure.

---
 rtl/board_render_pkg.sv | 32 +++
 rtl/board_pixel_color.sv | 33 +++
 rtl/board_frame_renderer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/board_render_pkg.sv
// Shared constants for the checkers board renderer: status codes, colours and FSM states.
package board_render_pkg;

  localparam int unsigned EMPTY      = 0;
  localparam int unsigned RED        = 1;
  localparam int unsigned BLACK      = 2;
  localparam int unsigned RED_KING   = 3;
  localparam int unsigned BLACK_KING = 4;

  localparam logic [23:0] BG     = 24'h000000;
  localparam logic [23:0] LIGHT  = 24'hF0D9B5;
  localparam logic [23:0] DARK   = 24'h769656;
  localparam logic [23:0] CURSOR = 24'hFFFF00;
  localparam logic [23:0] UNDEF  = 24'hFF00FF;

  // Piece colours by status code; entry 0 is never shown (empty cells use the square colour).
  localparam logic [23:0] PALETTE [8] = '{
    EMPTY:      BG,
    RED:        24'hC00000,
    BLACK:      24'h202020,
    RED_KING:   24'hFF6060,
    BLACK_KING: 24'h606060,
    default:    UNDEF
  };

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StFinish
  } state_e;

endpackage

// File: rtl/board_pixel_color.sv
// Colour of one virtual pixel from its cell status and position flags.
module board_pixel_color
  import board_render_pkg::*;
#(
  parameter int unsigned CELL_BITS = 3
) (
  input  logic [CELL_BITS-1:0] status,
  input  logic                 parity,
  input  logic                 in_board,
  input  logic                 cursor_edge,
  output logic [23:0]          color
);

  logic [31:0] status_w;
  assign status_w = 32'(status);

  // Priority: background, cursor frame, empty square, piece palette, undefined codes.
  always_comb begin
    color = BG;
    if (!in_board) begin
      color = BG;
    end else if (cursor_edge) begin
      color = CURSOR;
    end else if (status_w == EMPTY) begin
      color = parity ? DARK : LIGHT;
    end else if (status_w < 32'd8) begin
      color = PALETTE[3'(status)];
    end else begin
      color = UNDEF;
    end
  end

endmodule

// File: rtl/board_frame_renderer.sv
// Sweeps the virtual frame buffer once per start, writing one board colour per pixel.
module board_frame_renderer
  import board_render_pkg::*;
#(
  parameter int unsigned FB_W      = 160,
  parameter int unsigned FB_H      = 120,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned BOARD_N   = 8,
  parameter int unsigned CELL_BITS = 3,
  parameter int unsigned CELL_PX   = 12,
  parameter int unsigned ORIGIN_X  = 32,
  parameter int unsigned ORIGIN_Y  = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BOARD_N*BOARD_N*CELL_BITS-1:0] board,
  input  logic [$clog2(BOARD_N)-1:0]           cursor_x,
  input  logic [$clog2(BOARD_N)-1:0]           cursor_y,
  input  logic                                 cursor_en,
  input  logic                                 start,
  input  logic                                 wr_ready,
  output logic [ADDR_W-1:0]                    wr_addr,
  output logic [23:0]                          wr_data,
  output logic                                 wr_en,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned BoardW = BOARD_N * BOARD_N * CELL_BITS;
  localparam int unsigned XW     = $clog2(FB_W);
  localparam int unsigned YW     = $clog2(FB_H);
  localparam int unsigned XW1    = XW + 1;
  localparam int unsigned YW1    = YW + 1;
  localparam int unsigned CW     = $clog2(BOARD_N);
  localparam int unsigned PW     = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int unsigned IW     = $clog2(BoardW);
  localparam int unsigned Span   = BOARD_N * CELL_PX;

  localparam logic [XW-1:0]     XLast    = XW'(FB_W - 1);
  localparam logic [XW:0]       XBeg     = XW1'(ORIGIN_X);
  localparam logic [XW:0]       XEnd     = XW1'(ORIGIN_X + Span);
  localparam logic [YW:0]       YBeg     = YW1'(ORIGIN_Y);
  localparam logic [YW:0]       YEnd     = YW1'(ORIGIN_Y + Span);
  localparam logic [PW-1:0]     PxLast   = PW'(CELL_PX - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(FB_W * FB_H - 1);

  state_e            state;
  logic [BoardW-1:0] snap_board;
  logic [CW-1:0]     snap_cx, snap_cy;
  logic              snap_cen;

  // Position of the pixel currently presented on wr_addr/wr_data.
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [PW-1:0] px_q, py_q;
  logic [CW-1:0] cx_q, cy_q;

  // Position of the pixel to be loaded next (pixel 0 when starting a frame).
  logic [XW-1:0]     nx;
  logic [YW-1:0]     ny;
  logic [PW-1:0]     npx, npy;
  logic [CW-1:0]     ncx, ncy;
  logic [ADDR_W-1:0] naddr;

  logic load_first, last_write, load;
  logic in_x, in_y, row_end;

  assign load_first = (state == StIdle) && start;
  assign last_write = (state == StDraw) && wr_ready && (wr_addr == AddrLast);
  assign load       = load_first || ((state == StDraw) && wr_ready && !last_write);

  // Row-major increment of address, coordinates, in-cell and cell counters.
  always_comb begin
    nx      = '0;
    ny      = '0;
    npx     = '0;
    npy     = '0;
    ncx     = '0;
    ncy     = '0;
    naddr   = '0;
    in_x    = ({1'b0, x_q} >= XBeg) && ({1'b0, x_q} < XEnd);
    in_y    = ({1'b0, y_q} >= YBeg) && ({1'b0, y_q} < YEnd);
    row_end = (x_q == XLast);
    if (!load_first) begin
      naddr = wr_addr + 1'b1;
      nx    = row_end ? '0 : x_q + 1'b1;
      ny    = row_end ? y_q + 1'b1 : y_q;
      npx   = px_q;
      ncx   = cx_q;
      npy   = py_q;
      ncy   = cy_q;
      if ({1'b0, nx} == XBeg) begin
        npx = '0;
        ncx = '0;
      end else if (in_x) begin
        if (px_q == PxLast) begin
          npx = '0;
          ncx = cx_q + 1'b1;
        end else begin
          npx = px_q + 1'b1;
        end
      end
      if (row_end) begin
        if ({1'b0, ny} == YBeg) begin
          npy = '0;
          ncy = '0;
        end else if (in_y) begin
          if (py_q == PxLast) begin
            npy = '0;
            ncy = cy_q + 1'b1;
          end else begin
            npy = py_q + 1'b1;
          end
        end
      end
    end
  end

  // The first pixel is coloured from the live inputs, which equal the snapshot being taken.
  logic [BoardW-1:0]    src_board;
  logic [CW-1:0]        src_cx, src_cy;
  logic                 src_cen;
  logic [IW-1:0]        cell_idx;
  logic [CELL_BITS-1:0] status;
  logic                 n_in_board, n_edge, cursor_edge, parity;
  logic [23:0]          color;

  assign src_board   = (state == StIdle) ? board     : snap_board;
  assign src_cx      = (state == StIdle) ? cursor_x  : snap_cx;
  assign src_cy      = (state == StIdle) ? cursor_y  : snap_cy;
  assign src_cen     = (state == StIdle) ? cursor_en : snap_cen;
  assign cell_idx    = IW'((32'(ncy) * BOARD_N + 32'(ncx)) * CELL_BITS);
  assign status      = src_board[cell_idx +: CELL_BITS];
  assign n_in_board  = ({1'b0, nx} >= XBeg) && ({1'b0, nx} < XEnd) &&
                       ({1'b0, ny} >= YBeg) && ({1'b0, ny} < YEnd);
  assign n_edge      = (npx == '0) || (npx == PxLast) || (npy == '0) || (npy == PxLast);
  assign cursor_edge = src_cen && (ncx == src_cx) && (ncy == src_cy) && n_edge;
  assign parity      = ncx[0] ^ ncy[0];

  board_pixel_color #(
    .CELL_BITS(CELL_BITS)
  ) u_color (
    .status     (status),
    .parity     (parity),
    .in_board   (n_in_board),
    .cursor_edge(cursor_edge),
    .color      (color)
  );

  // Frame FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      snap_board <= '0;
      snap_cx    <= '0;
      snap_cy    <= '0;
      snap_cen   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (load) begin
        x_q     <= nx;
        y_q     <= ny;
        px_q    <= npx;
        py_q    <= npy;
        cx_q    <= ncx;
        cy_q    <= ncy;
        wr_addr <= naddr;
        wr_data <= color;
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            snap_board <= board;
            snap_cx    <= cursor_x;
            snap_cy    <= cursor_y;
            snap_cen   <= cursor_en;
            wr_en      <= 1'b1;
            busy       <= 1'b1;
            state      <= StDraw;
          end
        end
        StDraw: begin
          if (last_write) begin
            wr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StFinish;
          end
        end
        StFinish: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
